int_ctrl: RTL and testbench

Interrupt controller that sequences the execute stage's interrupt entry and return. It sits beside `exe_stage` and owns the `int` and `int_state` inputs of that stage. It latches edge-triggered requests from peripheral sources such as audio timers and the bitmap DMA, applies a software mask, and picks the highest-priority enabled source. It waits for a safe pipeline point, then issues a one-cycle entry pulse with a vector address and holds the in-service state until the handler's `ret` commits.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/int_prio_enc.sv | 21 ++
 rtl/int_ctrl.sv | 108 ++++++++++
 tb/tb_int_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt FSM encoding, default vector layout and
// the widths of the exe_stage interrupt ports.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      ENTER   = 2'd2,
      SERVICE = 2'd3
   } int_fsm_e;

   localparam logic [15:0] DEF_VEC_BASE   = 16'h0010;
   localparam int          DEF_VEC_STRIDE = 4;

   localparam int EXE_INT_W       = 1;
   localparam int EXE_INT_STATE_W = 1;
   localparam int EXE_VEC_W       = 16;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: sel is the lowest set bit of req,
// any flags that at least one bit is set.
module int_prio_enc #(
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic [N-1:0]     req,
   output logic [SEL_W-1:0] sel,
   output logic             any
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no latch is inferred.
      sel = '0;
      any = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) sel = SEL_W'(i);
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches irq edges, masks, picks the lowest enabled
// source and sequences entry/service/return for the execute stage.
module int_ctrl
   import cpu_pkg::*;
#(
   parameter int          NUM_SRC    = 4,
   parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
   parameter int          VEC_STRIDE = DEF_VEC_STRIDE
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC-1:0]            irq,
   input  logic                          mask_we,
   input  logic [NUM_SRC-1:0]            mask_wdata,
   input  logic                          safe,
   input  logic                          ret_commit,
   output logic [EXE_INT_W-1:0]          int_req,
   output logic [EXE_VEC_W-1:0]          int_vec,
   output logic [EXE_INT_STATE_W-1:0]    int_state,
   output logic [NUM_SRC-1:0]            irq_ack,
   output logic [NUM_SRC-1:0]            pending,
   output logic [NUM_SRC-1:0]            mask
);

   localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   int_fsm_e           state_q;
   logic [SEL_W-1:0]   sel_q;
   logic [NUM_SRC-1:0] irq_q;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] mask_q;
   logic               int_state_q;

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] eligible;
   logic [SEL_W-1:0]   enc_sel;
   logic               enc_any;

   assign rise     = irq & ~irq_q;
   assign eligible = pending_q & mask_q;

   int_prio_enc #(
      .N     (NUM_SRC),
      .SEL_W (SEL_W)
   ) u_prio (
      .req (eligible),
      .sel (enc_sel),
      .any (enc_any)
   );

   // Outputs decode only registered state; sel_q is frozen for the ENTER cycle.
   assign int_req   = (state_q == ENTER);
   assign irq_ack   = int_req ? (NUM_SRC'(1) << sel_q) : '0;
   assign int_vec   = int_req ? (VEC_BASE + 16'(sel_q) * 16'(VEC_STRIDE)) : '0;
   assign int_state = int_state_q;
   assign pending   = pending_q;
   assign mask      = mask_q;

   // A fresh edge on the source being acknowledged keeps its pending bit set.
   assign pending_d = (pending_q & ~irq_ack) | rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q     <= '0;
         pending_q <= '0;
         mask_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         irq_q     <= irq;
         pending_q <= pending_d;
         if (mask_we) mask_q <= mask_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         int_state_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enc_any) state_q <= WAIT;
            end
            WAIT: begin
               if (!enc_any) begin
                  state_q <= IDLE;
               end else if (safe) begin
                  state_q <= ENTER;
                  sel_q   <= enc_sel;
               end
            end
            ENTER: begin
               state_q     <= SERVICE;
               int_state_q <= 1'b1;
            end
            SERVICE: begin
               if (ret_commit) begin
                  state_q     <= IDLE;
                  int_state_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_int_ctrl;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] irq = '0;
   logic         mask_we = 1'b0;
   logic [N-1:0] mask_wdata = '0;
   logic         safe = 1'b0;
   logic         ret_commit = 1'b0;

   logic         int_req;
   logic [15:0]  int_vec;
   logic         int_state;
   logic [N-1:0] irq_ack;
   logic [N-1:0] pending;
   logic [N-1:0] mask;

   int_ctrl #(
      .NUM_SRC    (N),
      .VEC_BASE   (16'h0010),
      .VEC_STRIDE (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq        (irq),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .safe       (safe),
      .ret_commit (ret_commit),
      .int_req    (int_req),
      .int_vec    (int_vec),
      .int_state  (int_state),
      .irq_ack    (irq_ack),
      .pending    (pending),
      .mask       (mask)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int req_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: pending/mask sets plus three flags describing where
   // the controller is in the entry/return sequence.
   logic [N-1:0] m_pend, m_mask, m_prev;
   bit           m_armed, m_enter, m_svc;
   int           m_sel;

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_prev = '0;
      m_armed = 0; m_enter = 0; m_svc = 0; m_sel = 0;
   endtask

   task automatic model_step();
      int           lo;
      logic [N-1:0] nxt;
      lo  = lowest(m_pend & m_mask);
      nxt = m_pend;
      if (m_enter) nxt[m_sel] = 1'b0;
      nxt = nxt | (irq & ~m_prev);
      if (m_enter) begin
         m_enter = 0;
         m_svc   = 1;
      end else if (m_svc) begin
         if (ret_commit) m_svc = 0;
      end else if (m_armed) begin
         if (lo < 0) m_armed = 0;
         else if (safe) begin
            m_armed = 0;
            m_enter = 1;
            m_sel   = lo;
         end
      end else if (lo >= 0) begin
         m_armed = 1;
      end
      m_pend = nxt;
      m_prev = irq;
      if (mask_we) m_mask = mask_wdata;
   endtask

   always begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_step();
      #1;
      if (int_req === 1'b1) req_seen++;
      check("int_req",   32'(int_req),   32'(m_enter));
      check("int_vec",   32'(int_vec),   m_enter ? 32'(16'h0010 + m_sel * 4) : 32'h0);
      check("irq_ack",   32'(irq_ack),   m_enter ? (32'h1 << m_sel) : 32'h0);
      check("int_state", 32'(int_state), 32'(m_svc));
      check("pending",   32'(pending),   32'(m_pend));
      check("mask",      32'(mask),      32'(m_mask));
   end

   // Waits (bounded) for int_req at negedges; lat = posedges since t0.
   task automatic wait_req(input string name, input int t0, input int max, output int lat);
      lat = -1;
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         if (int_req) begin
            lat = cyc - t0;
            break;
         end
      end
      check({name, "_seen"}, 32'(int_req), 32'h1);
   endtask

   task automatic write_mask(input logic [N-1:0] m);
      mask_we = 1'b1; mask_wdata = m;
      @(negedge clk);
      mask_we = 1'b0;
   endtask

   task automatic pulse_irq(input int i);
      irq[i] = 1'b1;
      @(negedge clk);
      irq[i] = 1'b0;
   endtask

   task automatic do_ret();
      ret_commit = 1'b1;
      @(negedge clk);
      ret_commit = 1'b0;
   endtask

   initial begin
      int t0, lat, pre;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_int_state", 32'(int_state), 32'h0);
      check("rst_pending",   32'(pending),   32'h0);
      check("rst_mask",      32'(mask),      32'h0);

      // Single request, minimum latency.
      write_mask(4'b1111);
      safe = 1'b1;
      t0 = cyc;
      pulse_irq(2);
      wait_req("t1", t0, 6, lat);
      check("t1_lat", 32'(lat), 32'd3);
      check("t1_vec", 32'(int_vec), 32'h0018);
      check("t1_ack", 32'(irq_ack), 32'b0100);
      @(negedge clk);
      check("t1_state", 32'(int_state), 32'h1);
      check("t1_pend2", 32'(pending[2]), 32'h0);
      do_ret();
      check("t1_ret", 32'(int_state), 32'h0);

      // Priority with late higher-priority arrival.
      safe = 1'b0;
      irq[3] = 1'b1;
      @(negedge clk);
      irq[3] = 1'b0; irq[1] = 1'b1;
      @(negedge clk);
      irq[1] = 1'b0;
      repeat (3) @(negedge clk);
      safe = 1'b1;
      wait_req("t2a", cyc, 4, lat);
      check("t2a_vec", 32'(int_vec), 32'h0014);
      check("t2_pend3", 32'(pending[3]), 32'h1);
      @(negedge clk);
      do_ret();
      wait_req("t2b", cyc, 6, lat);
      check("t2b_vec", 32'(int_vec), 32'h001C);
      @(negedge clk);
      do_ret();

      // Masked request latches but does not fire until enabled.
      write_mask(4'b0000);
      pulse_irq(0);
      pre = req_seen;
      repeat (4) @(negedge clk);
      check("t3_pend", 32'(pending), 32'b0001);
      check("t3_noreq", 32'(req_seen - pre), 32'h0);
      t0 = cyc;
      write_mask(4'b0001);
      wait_req("t3", t0, 5, lat);
      check("t3_lat_le3", 32'(lat > 0 && lat <= 3), 32'h1);
      check("t3_vec", 32'(int_vec), 32'h0010);
      @(negedge clk);
      do_ret();

      // Mask-out while waiting for a safe point.
      write_mask(4'b1111);
      safe = 1'b0;
      pulse_irq(2);
      repeat (3) @(negedge clk);
      pre = req_seen;
      write_mask(4'b0000);
      safe = 1'b1;
      repeat (4) @(negedge clk);
      check("t4_noreq", 32'(req_seen - pre), 32'h0);
      check("t4_pend2", 32'(pending[2]), 32'h1);
      write_mask(4'b1111);
      wait_req("t4", cyc, 5, lat);
      check("t4_vec", 32'(int_vec), 32'h0018);
      @(negedge clk);
      do_ret();

      // ret in IDLE is ignored; re-request during SERVICE with ret.
      do_ret();
      check("t5_idle_state", 32'(int_state), 32'h0);
      check("t5_idle_req", 32'(int_req), 32'h0);
      pulse_irq(0);
      wait_req("t5a", cyc, 6, lat);
      @(negedge clk);
      irq[0] = 1'b1; ret_commit = 1'b1;
      t0 = cyc;
      @(negedge clk);
      irq[0] = 1'b0; ret_commit = 1'b0;
      check("t5_drop", 32'(int_state), 32'h0);
      wait_req("t5b", t0, 6, lat);
      check("t5b_gap", 32'(lat), 32'd3);
      check("t5b_vec", 32'(int_vec), 32'h0010);
      @(negedge clk);
      do_ret();

      // Asynchronous reset in the middle of a handler.
      pulse_irq(1);
      wait_req("t6a", cyc, 6, lat);
      @(negedge clk);
      pulse_irq(3);
      check("t6_pend3", 32'(pending[3]), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_state", 32'(int_state), 32'h0);
      check("t6_rst_pend",  32'(pending),   32'h0);
      check("t6_rst_mask",  32'(mask),      32'h0);
      check("t6_rst_req",   32'(int_req),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      pre = req_seen;
      repeat (6) @(negedge clk);
      check("t6_noreq", 32'(req_seen - pre), 32'h0);
      write_mask(4'b1111);
      pulse_irq(2);
      wait_req("t6b", cyc, 6, lat);
      check("t6b_vec", 32'(int_vec), 32'h0018);
      @(negedge clk);
      do_ret();

      // Randomized traffic with one mid-run reset.
      for (int c = 0; c < 3000; c++) begin
         irq        = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
         mask_we    = ($urandom_range(0, 19) == 0);
         mask_wdata = N'($urandom_range(0, 15));
         safe       = ($urandom_range(0, 2) != 0);
         ret_commit = ($urandom_range(0, 5) == 0);
         if (c == 1500) rst_n = 1'b0;
         if (c == 1502) rst_n = 1'b1;
         @(negedge clk);
      end
      irq = '0; mask_we = 1'b0; ret_commit = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
